// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between VGA scanout fetch and the CPU bus.
// Video has fixed priority. One access is issued per clock. Read data and the completion
// strobe return two cycles after the grant.
// Optional starvation guard: define VRAM_STARVE_GUARD_EN to build run_cnt, which forces one
// CPU grant after MAX_VID_RUN consecutive video grants while the CPU is waiting.

module vram_arbiter #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_VID_RUN = 8
) (
  input  logic              CLOCK_50,
  input  logic              KEY0_N,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (MAX_VID_RUN < 1) begin : g_param_check
    $error("MAX_VID_RUN must be at least 1");
  end

  typedef enum logic [1:0] {
    TagNone = 2'd0,
    TagVid  = 2'd1,
    TagCpu  = 2'd2
  } tag_e;

  tag_e tag1_q, tag1_d, tag2_q;
  logic guard_trip;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int unsigned RunW = $clog2(MAX_VID_RUN + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_VID_RUN);

  logic [RunW-1:0] run_cnt_q, run_cnt_d;

  // Count video wins while the CPU waits; saturate so the trip condition stays stable.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (cpu_gnt || !cpu_req) begin
      run_cnt_d = '0;
    end else if (vid_gnt && (run_cnt_q != RunMax)) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLOCK_50 or negedge KEY0_N) begin
    if (!KEY0_N) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign guard_trip = (run_cnt_q == RunMax);
`else
  assign guard_trip = 1'b0;
`endif

  // Grants are combinational and forced low while reset is asserted.
  assign vid_gnt = KEY0_N & vid_req & ~guard_trip;
  assign cpu_gnt = KEY0_N & cpu_req & ~vid_gnt;

  // Tag of the access being issued this cycle.
  always_comb begin
    tag1_d = TagNone;
    if (vid_gnt) begin
      tag1_d = TagVid;
    end else if (cpu_gnt) begin
      tag1_d = TagCpu;
    end
  end

  // Issue stage: register the winning request onto the RAM port.
  always_ff @(posedge CLOCK_50 or negedge KEY0_N) begin
    if (!KEY0_N) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= vid_gnt | cpu_gnt;
      ram_we <= cpu_gnt & cpu_we;
      if (vid_gnt) begin
        ram_addr <= vid_addr;
      end else if (cpu_gnt) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end
    end
  end

  // Tag pipeline: tag2 lines up with the RAM read data one cycle after ram_en.
  always_ff @(posedge CLOCK_50 or negedge KEY0_N) begin
    if (!KEY0_N) begin
      tag1_q <= TagNone;
      tag2_q <= TagNone;
    end else begin
      tag1_q <= tag1_d;
      tag2_q <= tag1_q;
    end
  end

  assign vid_valid = (tag2_q == TagVid);
  assign cpu_ack   = (tag2_q == TagCpu);

  // RAM read data is shared; each requester qualifies it with its own strobe.
  assign vid_rdata = ram_rdata;
  assign cpu_rdata = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a write-first single-port RAM model.
// Unwritten RAM locations read as addr[7:0] ^ 8'h3C.

module tb_vram_arbiter;

  logic        CLOCK_50;
  logic        KEY0_N;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_gnt;
  logic        vid_valid;
  logic [7:0]  vid_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  vram_arbiter #(
    .ADDR_W      (13),
    .DATA_W      (8),
    .MAX_VID_RUN (8)
  ) u_dut (
    .CLOCK_50  (CLOCK_50),
    .KEY0_N    (KEY0_N),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_gnt   (vid_gnt),
    .vid_valid (vid_valid),
    .vid_rdata (vid_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] pre(input logic [12:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Write-first RAM model, read data one cycle after ram_en.
  logic [7:0] mem     [0:8191];
  logic       written [0:8191];
  always @(posedge CLOCK_50) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
        ram_rdata         <= ram_wdata;
      end else begin
        ram_rdata <= (written[ram_addr] === 1'b1) ? mem[ram_addr] : pre(ram_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  logic exp_cpu, exp_vid, exp_valid, exp_ack, exp_en;

  initial begin
    KEY0_N    = 1'b0;
    vid_req   = 1'b1;
    vid_addr  = '0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    #3;
    check("rst_vid_gnt", vid_gnt, 0);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    vid_req = 1'b0;
    cpu_req = 1'b0;
    @(negedge CLOCK_50);
    KEY0_N = 1'b1;
    next_cycle();

    // CPU write 0x5A to 0x0123, then read it back in the next cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'h5A;
    #1;
    check("wr_cpu_gnt", cpu_gnt, 1);
    check("wr_vid_gnt", vid_gnt, 0);
    next_cycle();
    cpu_we = 1'b0;
    #1;
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("wr_ram_en", ram_en, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 13'h0123);
    check("wr_ram_wdata", ram_wdata, 8'h5A);
    check("wr_ack_early", cpu_ack, 0);
    next_cycle();
    cpu_req = 1'b0;
    #1;
    check("wr_ack", cpu_ack, 1);
    check("rd_ram_en", ram_en, 1);
    check("rd_ram_we", ram_we, 0);
    next_cycle();
    check("rd_ack", cpu_ack, 1);
    check("rd_data", cpu_rdata, 8'h5A);
    check("rd_ram_idle", ram_en, 0);
    next_cycle();
    check("rd_ack_done", cpu_ack, 0);

    // Video stream of 16 reads, addresses 0x0000..0x000F.
    for (int c = 0; c <= 18; c++) begin
      vid_req  = (c < 16);
      vid_addr = 13'(c);
      #1;
      exp_valid = (c >= 2 && c < 18);
      check("vs_gnt", vid_gnt, (c < 16));
      check("vs_valid", vid_valid, exp_valid);
      if (exp_valid) check("vs_data", vid_rdata, pre(13'(c - 2)));
      check("vs_no_ack", cpu_ack, 0);
      next_cycle();
    end

    // Contention: both requesters held.
    vid_req = 1'b1; vid_addr = 13'h0020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
    for (int c = 0; c < 20; c++) begin
      #1;
`ifdef VRAM_STARVE_GUARD_EN
      exp_cpu = ((c % 9) == 8);
`else
      exp_cpu = 1'b0;
`endif
      check("ct_cpu_gnt", cpu_gnt, exp_cpu);
      check("ct_vid_gnt", vid_gnt, !exp_cpu);
      check("ct_excl", vid_valid & cpu_ack, 0);
      next_cycle();
    end
    vid_req = 1'b0;
    #1;
    check("ct_release_cpu", cpu_gnt, 1);
    check("ct_release_vid", vid_gnt, 0);
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();

    // Interleave: video on even cycles, CPU reads on odd cycles.
    for (int c = 0; c <= 12; c++) begin
      exp_vid  = (c < 10) && ((c % 2) == 0);
      exp_cpu  = (c < 10) && ((c % 2) == 1);
      vid_req  = exp_vid;
      cpu_req  = exp_cpu;
      cpu_we   = 1'b0;
      vid_addr = 13'(c);
      cpu_addr = 13'(16'h0100 + c);
      #1;
      exp_en    = (c >= 1 && c <= 10);
      exp_valid = (c >= 2 && c <= 11 && (c % 2) == 0);
      exp_ack   = (c >= 3 && c <= 11 && (c % 2) == 1);
      check("il_vid_gnt", vid_gnt, exp_vid);
      check("il_cpu_gnt", cpu_gnt, exp_cpu);
      check("il_ram_en", ram_en, exp_en);
      check("il_valid", vid_valid, exp_valid);
      check("il_ack", cpu_ack, exp_ack);
      if (exp_valid) check("il_vdata", vid_rdata, pre(13'(c - 2)));
      if (exp_ack) check("il_cdata", cpu_rdata, pre(13'(16'h0100 + c - 2)));
      next_cycle();
    end

    // Reset asserted in the middle of a video burst.
    for (int c = 0; c < 3; c++) begin
      vid_req  = 1'b1;
      vid_addr = 13'(16'h0200 + c);
      next_cycle();
    end
    #2;
    KEY0_N = 1'b0;
    #1;
    check("mr_vid_gnt", vid_gnt, 0);
    check("mr_cpu_gnt", cpu_gnt, 0);
    check("mr_ram_en", ram_en, 0);
    check("mr_ram_we", ram_we, 0);
    check("mr_ram_addr", ram_addr, 0);
    check("mr_ram_wdata", ram_wdata, 0);
    check("mr_vid_valid", vid_valid, 0);
    check("mr_cpu_ack", cpu_ack, 0);
    vid_req = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    KEY0_N = 1'b1;
    next_cycle();
    check("mr_post_valid0", vid_valid, 0);
    next_cycle();
    check("mr_post_valid1", vid_valid, 0);
    vid_req  = 1'b1;
    vid_addr = 13'h0005;
    #1;
    check("mr_regrant", vid_gnt, 1);
    next_cycle();
    vid_req = 1'b0;
    next_cycle();
    check("mr_regrant_valid", vid_valid, 1);
    check("mr_regrant_data", vid_rdata, pre(13'h0005));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
